wb_write_queue: RTL and testbench

WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

---
 rtl/wb_write_queue_if.sv | 47 ++++
 rtl/wb_write_queue.sv | 118 +++++++++++
 tb/tb_wb_write_queue.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_write_queue_if.sv
// Bundle of the ALU/load write ports, register-file write port, forwarding lookup and occupancy.
// The master modport is the requester side; the slave modport is the queue.
interface wb_write_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          a_valid;
    logic          a_ready;
    logic [4:0]    a_rd;
    logic [31:0]   a_data;

    logic          b_valid;
    logic          b_ready;
    logic [4:0]    b_rd;
    logic [31:0]   b_data;

    logic          wb_we;
    logic [4:0]    wb_addr;
    logic [31:0]   wb_data;

    logic [4:0]    q_addr;
    logic          q_hit;
    logic [31:0]   q_data;

    logic [CW-1:0] count;

    modport master (
        output a_valid, a_rd, a_data,
        output b_valid, b_rd, b_data,
        output q_addr,
        input  a_ready, b_ready,
        input  wb_we, wb_addr, wb_data,
        input  q_hit, q_data,
        input  count
    );

    modport slave (
        input  a_valid, a_rd, a_data,
        input  b_valid, b_rd, b_data,
        input  q_addr,
        output a_ready, b_ready,
        output wb_we, wb_addr, wb_data,
        output q_hit, q_data,
        output count
    );
endinterface

// File: rtl/wb_write_queue.sv
// Register-file write-back queue: merges ALU and load results into an in-order FIFO,
// retires one entry per cycle onto the register-file write port, and forwards pending data.
module wb_write_queue #(
    parameter int unsigned DEPTH = 4
) (
    input logic              clk,
    input logic              rst,
    wb_write_queue_if.slave  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [PW-1:0] wptr_a;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] free;

    logic [4:0]    rd_q   [DEPTH];
    logic [31:0]   data_q [DEPTH];

    logic          wb_we_q;
    logic [4:0]    wb_addr_q;
    logic [31:0]   wb_data_q;

    logic          a_ready;
    logic          b_ready;
    logic          a_fire;
    logic          b_fire;
    logic          enq_a;
    logic          enq_b;
    logic          pop;

    logic          q_hit;
    logic [31:0]   q_data;
    logic [PW-1:0] fwd_idx;

    // Free space is taken from the registered count, so a pop this cycle never opens a slot.
    always_comb begin
        free    = CW'(DEPTH) - count_q;
        b_ready = !rst && (free >= CW'(1));
        a_ready = !rst && ((free >= CW'(2)) || ((free >= CW'(1)) && !bus.b_valid));
    end

    always_comb begin
        b_fire  = bus.b_valid && b_ready;
        a_fire  = bus.a_valid && a_ready;
        // Writes to x0 complete the handshake but are dropped.
        enq_b   = b_fire && (bus.b_rd != 5'd0);
        enq_a   = a_fire && (bus.a_rd != 5'd0);
        pop     = (count_q != '0);
        wptr_a  = wptr_q + PW'(enq_b);
        count_d = count_q + CW'(enq_a) + CW'(enq_b) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            wb_we_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            wptr_q  <= wptr_q + PW'(enq_a) + PW'(enq_b);
            rptr_q  <= rptr_q + PW'(pop);
            count_q <= count_d;
            wb_we_q <= pop;
            if (pop) begin
                wb_addr_q <= rd_q[rptr_q];
                wb_data_q <= data_q[rptr_q];
            end
        end
    end

    // Storage needs no reset: only entries covered by count are ever read.
    // The load entry takes the older slot when both ports enqueue together.
    always_ff @(posedge clk) begin
        if (enq_b) begin
            rd_q[wptr_q]   <= bus.b_rd;
            data_q[wptr_q] <= bus.b_data;
        end
        if (enq_a) begin
            rd_q[wptr_a]   <= bus.a_rd;
            data_q[wptr_a] <= bus.a_data;
        end
    end

    // Scan oldest to youngest so the last match wins; the wb register is older than any entry.
    always_comb begin
        q_hit   = 1'b0;
        q_data  = '0;
        fwd_idx = '0;
        if (bus.q_addr != 5'd0) begin
            if (wb_we_q && (wb_addr_q == bus.q_addr)) begin
                q_hit  = 1'b1;
                q_data = wb_data_q;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fwd_idx = rptr_q + PW'(i);
                if ((CW'(i) < count_q) && (rd_q[fwd_idx] == bus.q_addr)) begin
                    q_hit  = 1'b1;
                    q_data = data_q[fwd_idx];
                end
            end
        end
    end

    assign bus.a_ready = a_ready;
    assign bus.b_ready = b_ready;
    assign bus.wb_we   = wb_we_q;
    assign bus.wb_addr = wb_addr_q;
    assign bus.wb_data = wb_data_q;
    assign bus.q_hit   = q_hit;
    assign bus.q_data  = q_data;
    assign bus.count   = count_q;
endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: linear steps with hand-computed expectations.
module tb_wb_write_queue;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    wb_write_queue_if #(.DEPTH(4)) bus ();

    wb_write_queue #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.a_valid = v;
        bus.a_rd    = rd;
        bus.a_data  = d;
    endtask

    task automatic set_b(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.b_valid = v;
        bus.b_rd    = rd;
        bus.b_data  = d;
    endtask

    task automatic check_wb(input string tag, input logic we, input logic [4:0] addr,
                            input logic [31:0] data);
        check({tag, "_we"}, 32'(bus.wb_we), 32'(we));
        if (we) begin
            check({tag, "_addr"}, 32'(bus.wb_addr), 32'(addr));
            check({tag, "_data"}, bus.wb_data, data);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_a(1'b0, 5'd0, 32'd0);
        set_b(1'b0, 5'd0, 32'd0);
        bus.q_addr = 5'd0;

        // Reset state
        #2;
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_wb_we", 32'(bus.wb_we), 32'd0);
        check("rst_wb_addr", 32'(bus.wb_addr), 32'd0);
        check("rst_wb_data", bus.wb_data, 32'd0);
        check("rst_a_ready", 32'(bus.a_ready), 32'd0);
        check("rst_b_ready", 32'(bus.b_ready), 32'd0);
        check("rst_q_hit", 32'(bus.q_hit), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("idle_a_ready", 32'(bus.a_ready), 32'd1);
        check("idle_b_ready", 32'(bus.b_ready), 32'd1);

        // Single write: accept at edge N, on wb after edge N+1 only
        set_a(1'b1, 5'd5, 32'h1234_5678);
        bus.q_addr = 5'd5;
        #1;
        check("single_fwd_not_yet", 32'(bus.q_hit), 32'd0);
        step();
        set_a(1'b0, 5'd0, 32'd0);
        #1;
        check("single_count1", 32'(bus.count), 32'd1);
        check_wb("single_n0", 1'b0, 5'd0, 32'd0);
        check("single_fwd_hit", 32'(bus.q_hit), 32'd1);
        check("single_fwd_data", bus.q_data, 32'h1234_5678);
        step();
        check_wb("single_n1", 1'b1, 5'd5, 32'h1234_5678);
        check("single_count0", 32'(bus.count), 32'd0);
        step();
        check_wb("single_n2", 1'b0, 5'd0, 32'd0);
        check("single_addr_held", 32'(bus.wb_addr), 32'd5);

        // Dual accept: load entry retires first
        set_a(1'b1, 5'd7, 32'h7);
        set_b(1'b1, 5'd9, 32'h1);
        #1;
        check("dual_a_ready", 32'(bus.a_ready), 32'd1);
        check("dual_b_ready", 32'(bus.b_ready), 32'd1);
        step();
        set_a(1'b0, 5'd0, 32'd0);
        set_b(1'b0, 5'd0, 32'd0);
        bus.q_addr = 5'd9;
        #1;
        check("dual_count2", 32'(bus.count), 32'd2);
        check("dual_fwd9", bus.q_data, 32'h1);
        step();
        check_wb("dual_first", 1'b1, 5'd9, 32'h1);
        step();
        check_wb("dual_second", 1'b1, 5'd7, 32'h7);
        step();
        check_wb("dual_idle", 1'b0, 5'd0, 32'd0);

        // x0 writes are accepted and dropped
        set_b(1'b1, 5'd0, 32'hDEAD_BEEF);
        #1;
        check("x0_b_ready", 32'(bus.b_ready), 32'd1);
        step();
        set_b(1'b0, 5'd0, 32'd0);
        #1;
        check("x0_count", 32'(bus.count), 32'd0);
        check_wb("x0_n0", 1'b0, 5'd0, 32'd0);
        step();
        check_wb("x0_n1", 1'b0, 5'd0, 32'd0);

        // Heavy load: ready rules and in-order drain with pointer wrap
        set_a(1'b1, 5'd1, 32'h11);
        set_b(1'b1, 5'd2, 32'h22);
        step();
        set_a(1'b1, 5'd3, 32'h33);
        set_b(1'b1, 5'd4, 32'h44);
        #1;
        check("load_free2_a", 32'(bus.a_ready), 32'd1);
        check("load_free2_b", 32'(bus.b_ready), 32'd1);
        step();
        check("load_count3", 32'(bus.count), 32'd3);
        check_wb("load_w2", 1'b1, 5'd2, 32'h22);
        set_a(1'b1, 5'd6, 32'h66);
        set_b(1'b1, 5'd5, 32'h55);
        #1;
        check("load_free1_a_blocked", 32'(bus.a_ready), 32'd0);
        check("load_free1_b", 32'(bus.b_ready), 32'd1);
        step();
        set_b(1'b0, 5'd0, 32'd0);
        #1;
        check("load_count3b", 32'(bus.count), 32'd3);
        check_wb("load_w1", 1'b1, 5'd1, 32'h11);
        check("load_free1_a_alone", 32'(bus.a_ready), 32'd1);
        step();
        set_a(1'b0, 5'd0, 32'd0);
        check("load_count3c", 32'(bus.count), 32'd3);
        check_wb("load_w4", 1'b1, 5'd4, 32'h44);
        step();
        check_wb("load_w3", 1'b1, 5'd3, 32'h33);
        step();
        check_wb("load_w5", 1'b1, 5'd5, 32'h55);
        step();
        check_wb("load_w6", 1'b1, 5'd6, 32'h66);
        check("load_count0", 32'(bus.count), 32'd0);
        step();
        check_wb("load_idle", 1'b0, 5'd0, 32'd0);
        set_a(1'b1, 5'd10, 32'hAA);
        step();
        set_a(1'b0, 5'd0, 32'd0);
        step();
        check_wb("wrap_write", 1'b1, 5'd10, 32'hAA);
        step();

        // Forwarding: youngest match wins, FIFO younger than wb register
        set_b(1'b1, 5'd3, 32'h10);
        set_a(1'b1, 5'd3, 32'h20);
        step();
        set_a(1'b0, 5'd0, 32'd0);
        set_b(1'b0, 5'd0, 32'd0);
        bus.q_addr = 5'd3;
        #1;
        check("fwd_hit", 32'(bus.q_hit), 32'd1);
        check("fwd_young", bus.q_data, 32'h20);
        bus.q_addr = 5'd0;
        #1;
        check("fwd_x0_hit", 32'(bus.q_hit), 32'd0);
        check("fwd_x0_data", bus.q_data, 32'd0);
        bus.q_addr = 5'd8;
        #1;
        check("fwd_miss", 32'(bus.q_hit), 32'd0);
        bus.q_addr = 5'd3;
        step();
        check_wb("fwd_pop1", 1'b1, 5'd3, 32'h10);
        check("fwd_fifo_over_wb", bus.q_data, 32'h20);
        step();
        check("fwd_from_wb_hit", 32'(bus.q_hit), 32'd1);
        check("fwd_from_wb_data", bus.q_data, 32'h20);
        step();
        check("fwd_drained", 32'(bus.q_hit), 32'd0);

        // Async reset mid-operation with three pending entries
        set_a(1'b1, 5'd11, 32'hB1);
        set_b(1'b1, 5'd12, 32'hB2);
        step();
        set_a(1'b1, 5'd13, 32'hB3);
        set_b(1'b1, 5'd14, 32'hB4);
        step();
        set_a(1'b0, 5'd0, 32'd0);
        set_b(1'b0, 5'd0, 32'd0);
        bus.q_addr = 5'd13;
        check("ares_count3", 32'(bus.count), 32'd3);
        #1;
        rst = 1'b1;
        #1;
        check("ares_count", 32'(bus.count), 32'd0);
        check("ares_wb_we", 32'(bus.wb_we), 32'd0);
        check("ares_wb_addr", 32'(bus.wb_addr), 32'd0);
        check("ares_wb_data", bus.wb_data, 32'd0);
        check("ares_b_ready", 32'(bus.b_ready), 32'd0);
        check("ares_q_hit", 32'(bus.q_hit), 32'd0);
        check("ares_q_data", bus.q_data, 32'd0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_wb("ares_no_stale", 1'b0, 5'd0, 32'd0);
            check("ares_count_after", 32'(bus.count), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
